// File: rtl/memresp_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// default geometry/latency and the RW strobe encoding.
package memresp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_LATENCY = 3;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with synchronous write and a registered read port.
// Contents are never reset; only the read register clears on reset.
module mem_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // The read register doubles as the responder's dataOut, so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: latches a request, waits LATENCY edges, performs the
// access and holds MFC until the requester drops memEN.
module mem_responder
    import memresp_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memEN,
    input  logic              RW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              MFC,
    output logic              busy
);

    if (LATENCY == 0 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be within 1..15");
    end

    state_t            state;
    logic [3:0]        cnt;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              access;
    logic              we;
    logic              re;

    // The access fires on the final wait edge only if the requester is still asserting memEN.
    assign access = (state == WAIT) && memEN && (cnt == '0);
    assign we     = access && (rw_q == RW_WRITE);
    assign re     = access && (rw_q == RW_READ);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            MFC    <= 1'b0;
            rw_q   <= RW_READ;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memEN) begin
                        rw_q   <= RW;
                        addr_q <= addr;
                        data_q <= dataIn;
                        cnt    <= 4'(LATENCY - 1);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (!memEN) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        MFC   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!memEN) begin
                        MFC   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    MFC   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst),
        .we    (we),
        .re    (re),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (dataOut)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder at LATENCY 3, 1 and 15: directed
// table, abort and reset sequences, then randomized traffic vs a model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        me   [3];
    logic        rw   [3];
    logic [7:0]  ad   [3];
    logic [15:0] di   [3];
    logic [15:0] dout [3];
    logic        mfc  [3];
    logic        bsy  [3];

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mdl     [3][256];
    bit          vld     [3][256];
    logic [15:0] last_rd [3];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .memEN(me[0]), .RW(rw[0]), .addr(ad[0]),
        .dataIn(di[0]), .dataOut(dout[0]), .MFC(mfc[0]), .busy(bsy[0]));
    mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .memEN(me[1]), .RW(rw[1]), .addr(ad[1]),
        .dataIn(di[1]), .dataOut(dout[1]), .MFC(mfc[1]), .busy(bsy[1]));
    mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst), .memEN(me[2]), .RW(rw[2]), .addr(ad[2]),
        .dataIn(di[2]), .dataOut(dout[2]), .MFC(mfc[2]), .busy(bsy[2]));

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 15;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %h, expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble(input int i);
        rw[i] = 1'($urandom);
        ad[i] = 8'($urandom);
        di[i] = 16'($urandom);
    endtask

    // Full handshake; the transaction is expected to complete and return to idle.
    task automatic do_txn(input int i, input bit r, input logic [7:0] a, input logic [15:0] d, input int hold);
        int edges;
        me[i] = 1'b1; rw[i] = r; ad[i] = a; di[i] = d;
        tick();
        scramble(i);
        chk("busy_after_accept", i, 32'(bsy[i]), 32'd1);
        edges = 0;
        do begin
            if (edges > 0) scramble(i);
            tick();
            edges++;
        end while (!mfc[i] && edges < 40);
        chk("mfc_latency", i, edges, lat_of(i));
        if (r) begin
            last_rd[i] = mdl[i][a];
        end else begin
            mdl[i][a] = d;
            vld[i][a] = 1'b1;
        end
        chk(r ? "read_data" : "write_keeps_dataout", i, 32'(dout[i]), 32'(last_rd[i]));
        for (int h = 0; h < hold; h++) begin
            scramble(i);
            tick();
            chk("hold_mfc", i, 32'(mfc[i]), 32'd1);
            chk("hold_data", i, 32'(dout[i]), 32'(last_rd[i]));
        end
        me[i] = 1'b0;
        tick();
        chk("mfc_cleared", i, 32'(mfc[i]), 32'd0);
        chk("idle_after_drop", i, 32'(bsy[i]), 32'd0);
    endtask

    // Request then drop memEN after k wait edges (k < LATENCY): nothing may happen.
    task automatic do_abort(input int i, input bit r, input logic [7:0] a, input logic [15:0] d, input int k);
        me[i] = 1'b1; rw[i] = r; ad[i] = a; di[i] = d;
        tick();
        for (int e = 0; e < k; e++) begin
            chk("abort_wait_mfc", i, 32'(mfc[i]), 32'd0);
            tick();
        end
        chk("abort_busy", i, 32'(bsy[i]), 32'd1);
        me[i] = 1'b0;
        tick();
        chk("abort_mfc", i, 32'(mfc[i]), 32'd0);
        chk("abort_idle", i, 32'(bsy[i]), 32'd0);
        chk("abort_dataout", i, 32'(dout[i]), 32'(last_rd[i]));
    endtask

    typedef struct {
        int          inst;
        bit          rd;
        logic [7:0]  a;
        logic [15:0] d;
        int          hold;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{0, 1'b0, 8'h42, 16'h1234, 0, 16'h0000};
        tbl[1]  = '{0, 1'b1, 8'h42, 16'h0000, 5, 16'h1234};
        tbl[2]  = '{0, 1'b0, 8'h10, 16'h1111, 1, 16'h1234};
        tbl[3]  = '{0, 1'b0, 8'h00, 16'hA000, 0, 16'h1234};
        tbl[4]  = '{0, 1'b0, 8'h01, 16'hA001, 0, 16'h1234};
        tbl[5]  = '{0, 1'b0, 8'h02, 16'hA002, 0, 16'h1234};
        tbl[6]  = '{0, 1'b1, 8'h00, 16'h0000, 0, 16'hA000};
        tbl[7]  = '{0, 1'b1, 8'h01, 16'h0000, 0, 16'hA001};
        tbl[8]  = '{0, 1'b1, 8'h02, 16'h0000, 0, 16'hA002};
        tbl[9]  = '{1, 1'b0, 8'hFF, 16'hC0DE, 2, 16'h0000};
        tbl[10] = '{2, 1'b0, 8'h00, 16'hF00D, 2, 16'h0000};

        for (int i = 0; i < 3; i++) begin
            me[i] = 1'b0; rw[i] = 1'b0; ad[i] = '0; di[i] = '0;
            last_rd[i] = '0;
            for (int a = 0; a < 256; a++) vld[i][a] = 1'b0;
        end
        rst = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("reset_dataout", i, 32'(dout[i]), 32'd0);
            chk("reset_mfc", i, 32'(mfc[i]), 32'd0);
            chk("reset_busy", i, 32'(bsy[i]), 32'd0);
        end
        rst = 1'b1;

        for (int v = 0; v < 11; v++) begin
            do_txn(tbl[v].inst, tbl[v].rd, tbl[v].a, tbl[v].d, tbl[v].hold);
            chk("table_dataout", tbl[v].inst, 32'(dout[tbl[v].inst]), 32'(tbl[v].exp));
        end
        do_txn(1, 1'b1, 8'hFF, 16'h0, 0);
        chk("l1_read", 1, 32'(dout[1]), 32'h0000C0DE);
        do_txn(2, 1'b1, 8'h00, 16'h0, 0);
        chk("l15_read", 2, 32'(dout[2]), 32'h0000F00D);

        do_abort(0, 1'b0, 8'h10, 16'hBEEF, 1);
        do_txn(0, 1'b1, 8'h10, 16'h0, 0);
        chk("abort_readback", 0, 32'(dout[0]), 32'h00001111);

        do_txn(0, 1'b0, 8'h20, 16'h5A5A, 0);
        me[0] = 1'b1; rw[0] = 1'b0; ad[0] = 8'h20; di[0] = 16'hDEAD;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("midop_reset_dataout", 0, 32'(dout[0]), 32'd0);
        chk("midop_reset_mfc", 0, 32'(mfc[0]), 32'd0);
        chk("midop_reset_busy", 0, 32'(bsy[0]), 32'd0);
        me[0] = 1'b0;
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        #3 rst = 1'b1;
        do_txn(0, 1'b1, 8'h20, 16'h0, 0);
        chk("reset_retains_array", 0, 32'(dout[0]), 32'h00005A5A);

        for (int n = 0; n < 150; n++) begin
            int          i;
            logic [7:0]  a;
            logic [15:0] d;
            i = $urandom_range(0, 2);
            a = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            d = 16'($urandom);
            if ($urandom_range(0, 9) < 2) begin
                do_abort(i, 1'($urandom), a, d, $urandom_range(0, lat_of(i) - 1));
            end else if (vld[i][a] && $urandom_range(0, 1) == 1) begin
                do_txn(i, 1'b1, a, d, $urandom_range(0, 3));
            end else begin
                do_txn(i, 1'b0, a, d, $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter LATENCY, default 3, wait cycles from request sample to access; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 memEN  input  1  request strobe from memory FSM; held high until MFC seen.
REQ-007 RW  input  1  1 = read, 0 = write; sampled with memEN.
REQ-008 addr  input  ADDR_W  word address, driven from MAR.
REQ-009 dataIn  input  DATA_W  write data, driven from MDR.
REQ-010 dataOut  output  DATA_W  registered read data, fed to MDR.
REQ-011 MFC  output  1  memory function complete; registered.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 In IDLE, memEN sampled high at edge N SHALL latch addr, RW and dataIn, load the wait counter with LATENCY-1, and enter WAIT.
REQ-015 In WAIT, the counter SHALL decrement each edge while memEN is high; inputs changing after edge N SHALL be ignored.
REQ-016 At the WAIT edge where the counter equals 0 (edge N+LATENCY), the FSM SHALL perform the access, set MFC=1 and enter DONE.
REQ-017 Write access: the array word at the latched address SHALL take the latched data at edge N+LATENCY; dataOut SHALL be unchanged.
REQ-018 Read access: dataOut SHALL take the array word at the latched address at edge N+LATENCY, valid in the same cycle that MFC rises.
REQ-019 In DONE, MFC and dataOut SHALL hold while memEN is high.
REQ-020 memEN sampled low in DONE SHALL clear MFC on that edge and return to IDLE; a new request SHALL be accepted no earlier than the following edge.
REQ-021 memEN sampled low in WAIT SHALL abort: return to IDLE, no array write, dataOut unchanged, MFC stays 0.
REQ-022 A full transaction SHALL take LATENCY+2 edges minimum from request sample to IDLE with memEN dropped immediately after MFC.
REQ-023 The address space SHALL be 2**ADDR_W words with no out-of-range case; there is no wrap-around.
REQ-024 LATENCY outside 1..15 SHALL be rejected at elaboration.

Reset
REQ-025 rst low SHALL immediately force state IDLE, MFC=0, busy=0, dataOut=0 and counter=0, independent of clk.
REQ-026 Reset asserted mid-transaction SHALL cancel it with no array write; array contents are not reset and SHALL be retained.
REQ-027 After rst is released, the first request SHALL be accepted on the first edge with memEN high.

Structure
REQ-028 Package memresp_pkg SHALL hold the state encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10), the default ADDR_W/DATA_W/LATENCY constants and the RW_READ/RW_WRITE encodings.
REQ-029 Storage SHALL be a sub-module mem_array (synchronous write enable, synchronous registered read); the FSM, counter and latches remain in mem_responder.

Verification
REQ-030 Write then read: write 16'h1234 to 8'h42, then read 8'h42 -> MFC rises 3 edges after each memEN sample; the read returns dataOut=16'h1234 with MFC.
REQ-031 Handshake hold: keep memEN high 5 cycles after MFC -> MFC and dataOut stay stable; MFC clears on the edge memEN is sampled low.
REQ-032 Abort: start a write of 16'hBEEF to 8'h10 and drop memEN after 1 wait edge -> return to IDLE, MFC never rises, subsequent read of 8'h10 returns the old value.
REQ-033 Reset mid-operation: assert rst during WAIT of a write to 8'h20 -> MFC=0, busy=0 and dataOut=0 immediately; a later read of 8'h20 shows the prior contents.
REQ-034 Back-to-back: 3 writes to 8'h00..8'h02 with minimal gaps, then reads -> each completes in LATENCY+2 edges and the data matches.
REQ-035 Latency sweep: LATENCY=1 and LATENCY=15 -> MFC rises exactly LATENCY edges after memEN is sampled.
